fifo_to_ram: RTL

//   Drains exactly DATA_SIZE words from an upstream FIFO into a RAM at consecutive addresses 0..DATA_SIZE-1, starting on 'start'.

---
 rtl/cnn_accel_pkg.sv | 17 +
 rtl/fifo_to_ram_wr_pipe.sv | 96 +++++++++
 rtl/fifo_to_ram.sv | 115 +++++++++++
 3 files changed

// File: rtl/cnn_accel_pkg.sv
// Shared definitions for the CNN accelerator data movers.
//   fsm_state_e  : 2-bit mover FSM encoding (IDLE/RUN/DRAIN/DONE)
//   FIFO_RD_LAT  : cycles from FIFO pop to read data valid
//   RAM_RD_LAT   : cycles from RAM read address to read data valid
package cnn_accel_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } fsm_state_e;

    localparam int FIFO_RD_LAT = 1;
    localparam int RAM_RD_LAT  = 2;

endpackage

// File: rtl/fifo_to_ram_wr_pipe.sv
// Write pipeline of the FIFO-to-RAM mover: carries each pop's valid bit and
// RAM address until the matching FIFO data (and, when accumulating, the RAM
// read data) is available, then issues the RAM write.
// Configuration macro FIFO_TO_RAM_ACC_EN:
//   undefined : depth 1, ram_wdata = FIFO data, ram_rdata ignored
//   defined   : depth 2, ram_wdata = registered FIFO data + ram_rdata (wraps)
// Ports:
//   clk, rst        clock, asynchronous active-high reset
//   pop, pop_addr   pop strobe from the FSM and the word index being popped
//   data_from_fifo  FIFO read data, valid one cycle after pop
//   ram_rdata       RAM read data, valid two cycles after pop
//   ram_we/waddr/wdata  RAM write port
//   pipe_empty      no entry remains that is still to be written after this cycle
module fifo_to_ram_wr_pipe
    import cnn_accel_pkg::*;
#(
    parameter int AW = 16,
    parameter int DW = 32
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          pop,
    input  logic [AW-1:0] pop_addr,
    input  logic [DW-1:0] data_from_fifo,
    input  logic [DW-1:0] ram_rdata,
    output logic          ram_we,
    output logic [AW-1:0] ram_waddr,
    output logic [DW-1:0] ram_wdata,
    output logic          pipe_empty
);

    // Stage p1: one cycle after the pop, FIFO read data is on data_from_fifo
    logic          vld_p1_d, vld_p1_q;
    logic [AW-1:0] addr_p1_d, addr_p1_q;

    always_comb begin
        vld_p1_d  = pop;
        addr_p1_d = pop ? pop_addr : addr_p1_q;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vld_p1_q  <= 1'b0;
            addr_p1_q <= '0;
        end else begin
            vld_p1_q  <= vld_p1_d;
            addr_p1_q <= addr_p1_d;
        end
    end

`ifdef FIFO_TO_RAM_ACC_EN
    function automatic logic [DW-1:0] acc_add(input logic [DW-1:0] a,
                                              input logic [DW-1:0] b);
        return a + b;
    endfunction

    // Stage p2: two cycles after the pop, RAM read data for the same address arrives
    logic          vld_p2_d, vld_p2_q;
    logic [AW-1:0] addr_p2_d, addr_p2_q;
    logic [DW-1:0] data_p2_d, data_p2_q;

    always_comb begin
        vld_p2_d  = vld_p1_q;
        addr_p2_d = vld_p1_q ? addr_p1_q : addr_p2_q;
        data_p2_d = vld_p1_q ? data_from_fifo : data_p2_q;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vld_p2_q  <= 1'b0;
            addr_p2_q <= '0;
            data_p2_q <= '0;
        end else begin
            vld_p2_q  <= vld_p2_d;
            addr_p2_q <= addr_p2_d;
            data_p2_q <= data_p2_d;
        end
    end

    assign ram_we     = vld_p2_q;
    assign ram_waddr  = addr_p2_q;
    assign ram_wdata  = vld_p2_q ? acc_add(data_p2_q, ram_rdata) : '0;
    // An entry still in p1 will be written next cycle, so the pipe is not yet done.
    assign pipe_empty = !vld_p1_q;
`else
    logic unused_rdata;
    assign unused_rdata = ^ram_rdata;

    assign ram_we     = vld_p1_q;
    assign ram_waddr  = addr_p1_q;
    assign ram_wdata  = vld_p1_q ? data_from_fifo : '0;
    // Whatever sits in p1 is written this very cycle.
    assign pipe_empty = 1'b1;
`endif

endmodule

// File: rtl/fifo_to_ram.sv
// Drains DATA_SIZE words from an upstream FIFO into RAM addresses
// 0..DATA_SIZE-1 after a start pulse, then pulses done for one cycle.
// Configuration macro FIFO_TO_RAM_ACC_EN selects accumulate mode in the
// write pipeline (RAM word + FIFO word, write latency 2 instead of 1).
// Ports:
//   clk, rst        clock, asynchronous active-high reset
//   start           begin a transfer (accepted only in IDLE)
//   busy            high in RUN and DRAIN
//   done            one-cycle pulse in DONE
//   fifo_pop        FIFO read strobe, fifo_empty FIFO has no data
//   data_from_fifo  FIFO data, one cycle after fifo_pop
//   ram_raddr       RAM read address (the current word index)
//   ram_rdata       RAM read data, two cycles after ram_raddr
//   ram_we/ram_waddr/ram_wdata  RAM write port
module fifo_to_ram
    import cnn_accel_pkg::*;
#(
    parameter int CW        = 16,
    parameter int AW        = 16,
    parameter int DW        = 32,
    parameter int DATA_SIZE = 1024
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    output logic          busy,
    output logic          done,
    output logic          fifo_pop,
    input  logic          fifo_empty,
    input  logic [DW-1:0] data_from_fifo,
    output logic [AW-1:0] ram_raddr,
    input  logic [DW-1:0] ram_rdata,
    output logic          ram_we,
    output logic [AW-1:0] ram_waddr,
    output logic [DW-1:0] ram_wdata
);

    localparam logic [CW-1:0] LAST_CNT = CW'(DATA_SIZE - 1);

    fsm_state_e    state_d, state_q;
    logic [CW-1:0] cnt_d, cnt_q;
    logic          busy_d, busy_q;
    logic          done_d, done_q;
    logic          pop;
    logic          pipe_empty;

    assign pop = (state_q == RUN) && !fifo_empty;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = RUN;
                    cnt_d   = '0;
                end
            end
            RUN: begin
                if (pop) begin
                    cnt_d = cnt_q + 1'b1;
                    // Leave RUN on the final pop so no extra pop can be issued.
                    if (cnt_q == LAST_CNT) begin
                        state_d = DRAIN;
                    end
                end
            end
            DRAIN: begin
                if (pipe_empty) begin
                    state_d = DONE;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
        busy_d = (state_d == RUN) || (state_d == DRAIN);
        done_d = (state_d == DONE);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign busy      = busy_q;
    assign done      = done_q;
    assign fifo_pop  = pop;
    assign ram_raddr = AW'(cnt_q);

    fifo_to_ram_wr_pipe #(
        .AW (AW),
        .DW (DW)
    ) u_wr_pipe (
        .clk            (clk),
        .rst            (rst),
        .pop            (pop),
        .pop_addr       (AW'(cnt_q)),
        .data_from_fifo (data_from_fifo),
        .ram_rdata      (ram_rdata),
        .ram_we         (ram_we),
        .ram_waddr      (ram_waddr),
        .ram_wdata      (ram_wdata),
        .pipe_empty     (pipe_empty)
    );

endmodule
